// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if
// Purpose: bundles the request/response handshake and the word-addressed
// data-memory bus used by the MEM-stage load/store unit.
// Modports:
//   slave  - the load/store unit: takes requests, answers with a response,
//            and drives the memory strobes, index and write word.
//   master - the environment (MEM stage plus data memory): issues requests
//            and returns memory read data.
// Signals:
//   req_valid/req_ready/req_load/req_store/req_funct3/req_addr/req_wdata
//   rsp_valid/rsp_data/rsp_err
//   mem_read/mem_write (2-bit strobes), mem_addr (ADDR_W word index),
//   mem_wdata, mem_rdata (combinational read data)
interface mem_access_unit_if #(
  parameter int ADDR_W = 6
);
  logic              req_valid;
  logic              req_ready;
  logic              req_load;
  logic              req_store;
  logic [2:0]        req_funct3;
  logic [31:0]       req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic [31:0]       rsp_data;
  logic              rsp_err;
  logic [1:0]        mem_read;
  logic [1:0]        mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  modport slave (
    input  req_valid, req_load, req_store, req_funct3, req_addr, req_wdata,
    input  mem_rdata,
    output req_ready, rsp_valid, rsp_data, rsp_err,
    output mem_read, mem_write, mem_addr, mem_wdata
  );

  modport master (
    output req_valid, req_load, req_store, req_funct3, req_addr, req_wdata,
    output mem_rdata,
    input  req_ready, rsp_valid, rsp_data, rsp_err,
    input  mem_read, mem_write, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// mem_access_unit
// Purpose: load/store unit in the MEM stage of the RV32I core. Accepts one
// request at a time, performs byte/halfword lane selection with sign/zero
// extension on loads, and read-modify-write for sub-word stores against a
// word-addressed data memory. req_ready stays low until the access completes.
// Ports:
//   clk - clock, rising edge
//   rst - synchronous active-high reset
//   bus - mem_access_unit_if.slave (request, response and memory bus)
// Configuration:
//   MAU_MISALIGN_TRAP_EN - when defined, misaligned halfword/word requests
//   are rejected with rsp_err; when undefined, low address bits that do not
//   fit the access width are ignored.
module mem_access_unit #(
  parameter int ADDR_W = 6
) (
  input logic              clk,
  input logic              rst,
  mem_access_unit_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_STORE,
    S_RMW_RD,
    S_RMW_WR,
    S_RESP
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [2:0]        r_funct3;
  logic [1:0]        r_lane;
  logic [15:0]       r_wdata;
  logic [31:0]       r_rspData;
  logic              r_rspErr;
  logic [ADDR_W-1:0] r_memAddr;
  logic [31:0]       r_memWdata;

  logic              w_accept;
  logic              w_badF3;
  logic              w_misalign;
  logic              w_err;
  logic [1:0]        w_memRead;
  logic [1:0]        w_memWrite;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [31:0]       w_loadData;
  logic [31:0]       w_merged;

  // A request with neither load nor store set is not a request at all, so it
  // never consumes the idle slot.
  assign w_accept = bus.req_valid && (r_state == S_IDLE) &&
                    (bus.req_load || bus.req_store);

  // Store wins when both type bits are set, so the legality check follows it.
  always_comb begin
    w_badF3 = 1'b0;
    if (bus.req_store) begin
      w_badF3 = !(bus.req_funct3 == 3'b000 || bus.req_funct3 == 3'b001 ||
                  bus.req_funct3 == 3'b010);
    end else begin
      w_badF3 = (bus.req_funct3 == 3'b011 || bus.req_funct3 == 3'b110 ||
                 bus.req_funct3 == 3'b111);
    end
  end

`ifdef MAU_MISALIGN_TRAP_EN
  // funct3[1:0] encodes the access size for every legal code.
  assign w_misalign = ((bus.req_funct3[1:0] == 2'b01) && bus.req_addr[0]) ||
                      ((bus.req_funct3[1:0] == 2'b10) && (bus.req_addr[1:0] != 2'b00));
`else
  assign w_misalign = 1'b0;
`endif

  assign w_err = w_badF3 || w_misalign;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and memory strobes. Strobes are gated by rst so a reset
  // landing on a write cycle suppresses that write on the same edge.
  always_comb begin
    w_next     = r_state;
    w_memRead  = 2'b00;
    w_memWrite = 2'b00;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_err) begin
            w_next = S_RESP;
          end else if (!bus.req_store) begin
            w_next = S_LOAD;
          end else if (bus.req_funct3[1]) begin
            w_next = S_STORE;
          end else begin
            w_next = S_RMW_RD;
          end
        end
      end
      S_LOAD: begin
        w_memRead = 2'b01;
        w_next    = S_RESP;
      end
      S_STORE: begin
        w_memWrite = 2'b01;
        w_next     = S_RESP;
      end
      S_RMW_RD: begin
        w_memRead = 2'b01;
        w_next    = S_RMW_WR;
      end
      S_RMW_WR: begin
        w_memWrite = 2'b01;
        w_next     = S_RESP;
      end
      S_RESP: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
    if (rst) begin
      w_memRead  = 2'b00;
      w_memWrite = 2'b00;
    end
  end

  // Load lane selection and extension. Halfwords use addr[1] only, so an
  // odd address (when not trapped) reads the enclosing aligned halfword.
  always_comb begin
    case (r_lane)
      2'd0:    w_byte = bus.mem_rdata[7:0];
      2'd1:    w_byte = bus.mem_rdata[15:8];
      2'd2:    w_byte = bus.mem_rdata[23:16];
      default: w_byte = bus.mem_rdata[31:24];
    endcase
    w_half = r_lane[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
    case (r_funct3)
      3'b000:  w_loadData = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_loadData = {{16{w_half[15]}}, w_half};
      3'b100:  w_loadData = {24'h000000, w_byte};
      3'b101:  w_loadData = {16'h0000, w_half};
      default: w_loadData = bus.mem_rdata;
    endcase
  end

  // Sub-word store merge: the word read in RMW_RD with the addressed lane
  // replaced by the right-aligned store data.
  always_comb begin
    w_merged = bus.mem_rdata;
    if (r_funct3[0]) begin
      w_merged[{r_lane[1], 4'b0000} +: 16] = r_wdata;
    end else begin
      w_merged[{r_lane, 3'b000} +: 8] = r_wdata[7:0];
    end
  end

  // Request latch and response/bus registers. mem_addr and mem_wdata only
  // move when an access will use them, so they hold between accesses.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_funct3   <= 3'b000;
      r_lane     <= 2'b00;
      r_wdata    <= 16'h0000;
      r_rspData  <= 32'h0;
      r_rspErr   <= 1'b0;
      r_memAddr  <= '0;
      r_memWdata <= 32'h0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_funct3  <= bus.req_funct3;
            r_lane    <= bus.req_addr[1:0];
            r_wdata   <= bus.req_wdata[15:0];
            r_rspErr  <= w_err;
            r_rspData <= 32'h0;
            if (!w_err) begin
              r_memAddr <= bus.req_addr[ADDR_W+1:2];
              if (bus.req_store && bus.req_funct3[1]) begin
                r_memWdata <= bus.req_wdata;
              end
            end
          end
        end
        S_LOAD: begin
          r_rspData <= w_loadData;
        end
        S_RMW_RD: begin
          r_memWdata <= w_merged;
        end
        default: ;
      endcase
    end
  end

  assign bus.req_ready = (r_state == S_IDLE);
  assign bus.rsp_valid = (r_state == S_RESP);
  assign bus.rsp_data  = r_rspData;
  assign bus.rsp_err   = r_rspErr;
  assign bus.mem_read  = w_memRead;
  assign bus.mem_write = w_memWrite;
  assign bus.mem_addr  = r_memAddr;
  assign bus.mem_wdata = r_memWdata;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit
// Purpose: self-checking bench for mem_access_unit. Holds a word-addressed
// data memory driven by the unit's strobes and a behavioural reference model
// (plain array plus arithmetic on byte offsets). Runs a directed vector table,
// reset-during-access sequences and randomized requests.
// Honours MAU_MISALIGN_TRAP_EN in the same way as the design.
module tb_mem_access_unit;
  localparam int AW = 6;
  localparam int NW = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  mem_access_unit_if #(.ADDR_W(AW)) mif ();

  mem_access_unit #(.ADDR_W(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (mif)
  );

  // Memory attached to the unit, plus a preload port used during reset.
  logic [31:0]   tbMem  [NW];
  logic [31:0]   refMem [NW];
  logic          pokeEn = 1'b0;
  logic [AW-1:0] pokeIdx = '0;
  logic [31:0]   pokeData = 32'h0;

  assign mif.mem_rdata = tbMem[mif.mem_addr];

  // Memory writes happen on the rising edge while the write strobe is 01.
  always @(posedge clk) begin
    if (pokeEn) begin
      tbMem[pokeIdx] <= pokeData;
    end else if (mif.mem_write == 2'b01) begin
      tbMem[mif.mem_addr] <= mif.mem_wdata;
    end
  end

  int testsRun = 0;
  int testsFailed = 0;

  typedef struct {
    logic        ld;
    logic        st;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        expErr;
    logic [31:0] expData;
    int          expLat;
  } vec_t;

  vec_t vecs[$];

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic addVec(input logic ld, input logic st, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic expErr, input logic [31:0] expData, input int expLat);
    vec_t v;
    v.ld = ld; v.st = st; v.f3 = f3; v.addr = addr; v.wdata = wdata;
    v.expErr = expErr; v.expData = expData; v.expLat = expLat;
    vecs.push_back(v);
  endtask

  // Reference model: decides the outcome of one request from the ISA rules
  // and updates refMem. Latency counts cycles from accept edge to response.
  task automatic modelRequest(input logic ld, input logic st, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              output logic err, output logic [31:0] data,
                              output int lat, output int nRd, output int nWr);
    int          idx, off, size, boff;
    logic        isStore, legal;
    logic [31:0] w, mask, val;
    isStore = st;
    idx  = int'((addr >> 2) % NW);
    off  = int'(addr % 4);
    size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    if (isStore) legal = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2);
    else         legal = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    err = !legal;
`ifdef MAU_MISALIGN_TRAP_EN
    if (legal && (off % size) != 0) err = 1'b1;
`endif
    if (ld === 1'bx) err = 1'b1;
    data = 32'h0; nRd = 0; nWr = 0;
    w = refMem[idx];
    if (size == 1) begin boff = off;            mask = 32'hFF;   end
    else           begin boff = off - off % 2;  mask = 32'hFFFF; end
    if (err) begin
      lat = 1;
    end else if (!isStore) begin
      lat = 2; nRd = 1;
      if (size == 4) begin
        data = w;
      end else begin
        val = (w >> (8 * boff)) & mask;
        if (!f3[2] && (val & ((mask >> 1) + 1)) != 0) val = val | ~mask;
        data = val;
      end
    end else if (size == 4) begin
      lat = 2; nWr = 1;
      refMem[idx] = wdata;
    end else begin
      lat = 3; nRd = 1; nWr = 1;
      refMem[idx] = (w & ~(mask << (8 * boff))) | ((wdata & mask) << (8 * boff));
    end
  endtask

  // Drives one request, then watches the unit cycle by cycle (bounded) and
  // reports what it saw: response, latency, strobe counts, busy cycles.
  task automatic applyStimulus(input logic ld, input logic st, input logic [2:0] f3,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               output logic err, output logic [31:0] data,
                               output int lat, output int nRd, output int nWr,
                               output int nBusy, output int busBad);
    logic [AW-1:0] expIdx;
    expIdx = addr[AW+1:2];
    err = 1'bx; data = 32'hx; lat = 0; nRd = 0; nWr = 0; nBusy = 0; busBad = 0;
    @(negedge clk);
    mif.req_valid  = 1'b1;
    mif.req_load   = ld;
    mif.req_store  = st;
    mif.req_funct3 = f3;
    mif.req_addr   = addr;
    mif.req_wdata  = wdata;
    @(posedge clk);
    #1;
    mif.req_valid = 1'b0;
    mif.req_load  = 1'b0;
    mif.req_store = 1'b0;
    for (int c = 1; c <= 8 && lat == 0; c++) begin
      @(negedge clk);
      if (!mif.req_ready) nBusy++;
      if (mif.mem_read !== 2'b00) begin
        nRd++;
        if (mif.mem_read !== 2'b01 || mif.mem_addr !== expIdx) busBad++;
      end
      if (mif.mem_write !== 2'b00) begin
        nWr++;
        if (mif.mem_write !== 2'b01 || mif.mem_addr !== expIdx) busBad++;
      end
      if (mif.rsp_valid === 1'b1) begin
        lat  = c;
        err  = mif.rsp_err;
        data = mif.rsp_data;
      end
    end
  endtask

  task automatic runAndCheck(input string tag, input logic ld, input logic st,
                             input logic [2:0] f3, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic haveExp,
                             input logic tErr, input logic [31:0] tData, input int tLat);
    logic        mErr, dErr;
    logic [31:0] mData, dData;
    int          mLat, mRd, mWr, dLat, dRd, dWr, dBusy, dBad, idx;
    modelRequest(ld, st, f3, addr, wdata, mErr, mData, mLat, mRd, mWr);
    if (haveExp) begin
      mErr = tErr; mData = tData; mLat = tLat;
    end
    applyStimulus(ld, st, f3, addr, wdata, dErr, dData, dLat, dRd, dWr, dBusy, dBad);
    idx = int'((addr >> 2) % NW);
    checkOutput({tag, " latency"}, dLat, mLat);
    checkOutput({tag, " rsp_err"}, {31'h0, dErr}, {31'h0, mErr});
    checkOutput({tag, " rsp_data"}, dData, mData);
    checkOutput({tag, " read strobes"}, dRd, mRd);
    checkOutput({tag, " write strobes"}, dWr, mWr);
    checkOutput({tag, " ready-low cycles"}, dBusy, mLat);
    checkOutput({tag, " bad strobe/index"}, dBad, 0);
    checkOutput({tag, " memory word"}, tbMem[idx], refMem[idx]);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic        rErr;
    logic [31:0] rData, rAddr, rWdata;
    logic [2:0]  rF3;
    logic        rLd, rSt;
    int          nWr, nV, nBusy, bad;
    logic [31:0] w;

    mif.req_valid  = 1'b0;
    mif.req_load   = 1'b0;
    mif.req_store  = 1'b0;
    mif.req_funct3 = 3'b000;
    mif.req_addr   = 32'h0;
    mif.req_wdata  = 32'h0;

    // Preload memory while reset is held.
    for (int i = 0; i < NW; i++) begin
      @(negedge clk);
      w = (i == 0) ? 32'h80FF3344 : (i == 1) ? 32'h00000009 :
          (i == 2) ? 32'd25 : $urandom;
      pokeEn   = 1'b1;
      pokeIdx  = AW'(i);
      pokeData = w;
      refMem[i] = w;
    end
    @(negedge clk);
    pokeEn = 1'b0;

    // Reset state.
    checkOutput("reset req_ready", {31'h0, mif.req_ready}, 32'd1);
    checkOutput("reset rsp_valid", {31'h0, mif.rsp_valid}, 32'd0);
    checkOutput("reset rsp_err", {31'h0, mif.rsp_err}, 32'd0);
    checkOutput("reset rsp_data", mif.rsp_data, 32'h0);
    checkOutput("reset strobes", {28'h0, mif.mem_read, mif.mem_write}, 32'h0);
    checkOutput("reset mem_addr", {26'h0, mif.mem_addr}, 32'h0);
    checkOutput("reset mem_wdata", mif.mem_wdata, 32'h0);
    rst = 1'b0;

    // Directed vectors (memory contents evolve in table order).
    addVec(1, 0, 3'b010, 32'h8,   32'h0,        0, 32'd25,       2);
    addVec(0, 1, 3'b000, 32'h5,   32'h123456AB, 0, 32'h0,        3);
    addVec(1, 0, 3'b000, 32'h5,   32'h0,        0, 32'hFFFFFFAB, 2);
    addVec(1, 0, 3'b100, 32'h5,   32'h0,        0, 32'h000000AB, 2);
    addVec(1, 0, 3'b001, 32'h4,   32'h0,        0, 32'hFFFFAB09, 2);
`ifdef MAU_MISALIGN_TRAP_EN
    addVec(1, 0, 3'b010, 32'h6,   32'h0,        1, 32'h0,        1);
    addVec(1, 0, 3'b001, 32'h5,   32'h0,        1, 32'h0,        1);
`else
    addVec(1, 0, 3'b010, 32'h6,   32'h0,        0, 32'h0000AB09, 2);
    addVec(1, 0, 3'b001, 32'h5,   32'h0,        0, 32'hFFFFAB09, 2);
`endif
    addVec(1, 0, 3'b011, 32'h8,   32'h0,        1, 32'h0,        1);
    addVec(0, 1, 3'b001, 32'h6,   32'h12348001, 0, 32'h0,        3);
    addVec(1, 0, 3'b001, 32'h6,   32'h0,        0, 32'hFFFF8001, 2);
    addVec(1, 0, 3'b101, 32'h6,   32'h0,        0, 32'h00008001, 2);
    addVec(0, 1, 3'b010, 32'h10,  32'hDEADBEEF, 0, 32'h0,        2);
    addVec(1, 0, 3'b010, 32'h10,  32'h0,        0, 32'hDEADBEEF, 2);
    addVec(0, 1, 3'b011, 32'h10,  32'h11111111, 1, 32'h0,        1);
    addVec(1, 0, 3'b010, 32'h108, 32'h0,        0, 32'd25,       2);
    addVec(1, 1, 3'b000, 32'h8,   32'h0000007F, 0, 32'h0,        3);
    addVec(1, 0, 3'b000, 32'h8,   32'h0,        0, 32'h0000007F, 2);
    addVec(1, 0, 3'b000, 32'h3,   32'h0,        0, 32'hFFFFFF80, 2);
    addVec(1, 0, 3'b100, 32'h2,   32'h0,        0, 32'h000000FF, 2);
    addVec(1, 0, 3'b101, 32'h2,   32'h0,        0, 32'h000080FF, 2);
    addVec(1, 0, 3'b110, 32'h0,   32'h0,        1, 32'h0,        1);
    addVec(0, 1, 3'b100, 32'h0,   32'hFFFFFFFF, 1, 32'h0,        1);
`ifdef MAU_MISALIGN_TRAP_EN
    addVec(0, 1, 3'b010, 32'h11,  32'h55AA55AA, 1, 32'h0,        1);
    addVec(1, 0, 3'b010, 32'h10,  32'h0,        0, 32'hDEADBEEF, 2);
`else
    addVec(0, 1, 3'b010, 32'h11,  32'h55AA55AA, 0, 32'h0,        2);
    addVec(1, 0, 3'b010, 32'h10,  32'h0,        0, 32'h55AA55AA, 2);
`endif

    foreach (vecs[i]) begin
      runAndCheck($sformatf("vec%0d", i), vecs[i].ld, vecs[i].st, vecs[i].f3,
                  vecs[i].addr, vecs[i].wdata, 1'b1,
                  vecs[i].expErr, vecs[i].expData, vecs[i].expLat);
    end

    // req_valid with no type bit must be ignored.
    nBusy = 0; nV = 0; bad = 0;
    @(negedge clk);
    mif.req_valid = 1'b1;
    mif.req_load  = 1'b0;
    mif.req_store = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (!mif.req_ready) nBusy++;
      if (mif.rsp_valid) nV++;
      if (mif.mem_read != 2'b00 || mif.mem_write != 2'b00) bad++;
    end
    mif.req_valid = 1'b0;
    checkOutput("typeless request busy cycles", nBusy, 0);
    checkOutput("typeless request responses", nV, 0);
    checkOutput("typeless request strobes", bad, 0);

    // SH at 0x2 with reset landing in the read half of the read-modify-write.
    @(negedge clk);
    mif.req_valid = 1'b1; mif.req_store = 1'b1; mif.req_load = 1'b0;
    mif.req_funct3 = 3'b001; mif.req_addr = 32'h2; mif.req_wdata = 32'h0000BEEF;
    @(posedge clk);
    #1;
    mif.req_valid = 1'b0; mif.req_store = 1'b0;
    @(negedge clk);
    checkOutput("rstRmw read strobe", {30'h0, mif.mem_read}, 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("rstRmw strobes gated", {28'h0, mif.mem_read, mif.mem_write}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    checkOutput("rstRmw ready after reset", {31'h0, mif.req_ready}, 32'd1);
    nWr = 0; nV = 0;
    for (int c = 0; c < 5; c++) begin
      if (mif.mem_write != 2'b00) nWr++;
      if (mif.rsp_valid) nV++;
      @(negedge clk);
    end
    checkOutput("rstRmw write strobes", nWr, 0);
    checkOutput("rstRmw responses", nV, 0);
    checkOutput("rstRmw word0 unchanged", tbMem[0], refMem[0]);

    // SW at 0xC with reset landing on the write cycle.
    @(negedge clk);
    mif.req_valid = 1'b1; mif.req_store = 1'b1; mif.req_load = 1'b0;
    mif.req_funct3 = 3'b010; mif.req_addr = 32'hC; mif.req_wdata = 32'hCAFEF00D;
    @(posedge clk);
    #1;
    mif.req_valid = 1'b0; mif.req_store = 1'b0;
    @(negedge clk);
    checkOutput("rstStore write strobe", {30'h0, mif.mem_write}, 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("rstStore write gated", {30'h0, mif.mem_write}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    nV = 0;
    for (int c = 0; c < 4; c++) begin
      if (mif.rsp_valid) nV++;
      @(negedge clk);
    end
    checkOutput("rstStore responses", nV, 0);
    checkOutput("rstStore word3 unchanged", tbMem[3], refMem[3]);

    // Randomized requests against the reference model.
    for (int i = 0; i < 150; i++) begin
      case ($urandom_range(0, 3))
        0:       begin rLd = 1'b1; rSt = 1'b0; end
        1:       begin rLd = 1'b0; rSt = 1'b1; end
        2:       begin rLd = 1'b1; rSt = 1'b1; end
        default: begin rLd = 1'b1; rSt = 1'b0; end
      endcase
      rF3 = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) != 0) begin
        if (rSt) rF3 = 3'($urandom_range(0, 2));
        else     rF3 = ($urandom_range(0, 1) == 1) ? 3'($urandom_range(0, 2)) : 3'($urandom_range(4, 5));
      end
      rAddr  = $urandom;
      rWdata = $urandom;
      runAndCheck($sformatf("rand%0d", i), rLd, rSt, rF3, rAddr, rWdata,
                  1'b0, 1'b0, 32'h0, 0);
    end

    bad = 0;
    for (int i = 0; i < NW; i++) begin
      if (tbMem[i] !== refMem[i]) bad++;
    end
    checkOutput("final memory mismatching words", bad, 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end
endmodule
